// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, bit-period
// helper and line-rate defaults shared by the transmit and receive paths.
package uart_pkg;

    localparam int unsigned DEFAULT_CLK_HZ    = 50_000_000;
    localparam int unsigned DEFAULT_BAUD      = 115_200;
    localparam int unsigned DEFAULT_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic int unsigned clks_per_bit(
        input int unsigned clk_hz,
        input int unsigned baud
    );
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts enabled cycles and pulses bit_end on the
// last cycle of each bit period. Ports: clk, rst_n, clear, enable, bit_end.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT =
        clks_per_bit(DEFAULT_CLK_HZ, DEFAULT_BAUD)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int unsigned CW =
        (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    assign bit_end = enable && (count == LAST);

    // Wrapping at bit_end starts the next period at 0, so a state
    // change at a bit boundary always enters with a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (bit_end) count <= '0;
            else         count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity
// (macro UART_TX_PARITY_EN, PARITY_ODD selects odd), STOP_BITS stop bits.
// Ports: clk, rst_n, tx_start, tx_data, tx_ready, tx_done, tx.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = DEFAULT_CLK_HZ,
    parameter int unsigned BAUD      = DEFAULT_BAUD,
    parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS,
`ifdef UART_TX_PARITY_EN
    parameter bit          PARITY_ODD = 1'b0,
`endif
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_done,
    output logic                 tx
);

    localparam int unsigned CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned IW  =
        (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = (STOP_BITS == 2);

    tx_state_t            state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [IW-1:0]        bit_idx, idx_n;
    logic                 stop_idx, stop_n;
    logic                 tx_n;
    logic                 bit_end;
    logic                 accept;
`ifdef UART_TX_PARITY_EN
    logic                 par, par_n;
`endif

    uart_baud_cnt #(
        .CLKS_PER_BIT(CPB)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == IDLE),
        .enable (state != IDLE),
        .bit_end(bit_end)
    );

    // Done fires in the last cycle of the final stop bit; ready is
    // raised there too so a held tx_start chains frames with no gap.
    assign tx_done  = (state == STOP) && bit_end
                   && (stop_idx == LAST_STOP);
    assign tx_ready = (state == IDLE) || tx_done;
    assign accept   = tx_ready && tx_start;

    always_comb begin
        state_n = state;
        shift_n = shift;
        idx_n   = bit_idx;
        stop_n  = stop_idx;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        unique case (state)
            IDLE: ;
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    idx_n   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_n = {1'b0, shift[DATA_BITS-1:1]};
                    if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
                        stop_n  = 1'b0;
`endif
                    end else begin
                        idx_n = bit_idx + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    stop_n  = 1'b0;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (tx_done) state_n = IDLE;
                    else         stop_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (accept) begin
            state_n = START;
            shift_n = tx_data;
`ifdef UART_TX_PARITY_EN
            par_n   = (^tx_data) ^ PARITY_ODD;
`endif
        end

        // Line level follows the next state so tx is a plain flop.
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = par_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            bit_idx  <= idx_n;
            stop_idx <= stop_n;
            tx       <= tx_n;
`ifdef UART_TX_PARITY_EN
            par      <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: expected line levels, done and ready
// per bit are queued at stimulus time and checked cycle by cycle.
module tb_uart_tx;

    localparam int unsigned CLK_HZ = 50_000_000;
    localparam int unsigned BAUD   = 115_200;
    localparam int C  = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FB = 1 + 8 + PB + 1;
    localparam int F  = FB * C;

    typedef struct packed {
        logic lvl;
        logic last;
        logic idle;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_done, tx;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    uart_tx #(
        .CLK_HZ   (CLK_HZ),
        .BAUD     (BAUD),
        .DATA_BITS(8),
        .STOP_BITS(1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx_ready(tx_ready),
        .tx_done (tx_done),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    function automatic void push_frame(input logic [7:0] d);
        exp_q.push_back('{lvl: 1'b0, last: 1'b0, idle: 1'b0});
        for (int i = 0; i < 8; i++)
            exp_q.push_back('{lvl: d[i], last: 1'b0, idle: 1'b0});
`ifdef UART_TX_PARITY_EN
        exp_q.push_back('{lvl: ^d, last: 1'b0, idle: 1'b0});
`endif
        exp_q.push_back('{lvl: 1'b1, last: 1'b1, idle: 1'b0});
    endfunction

    function automatic void push_idle(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back('{lvl: 1'b1, last: 1'b0, idle: 1'b1});
    endfunction

    // Called right after a negedge; accept happens at the next posedge.
    task automatic start_frame(input logic [7:0] d, input logic hold);
        n_cmp++;
        if (tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL start_ready: tx_ready=%b required 1", tx_ready);
        end
        tx_data  = d;
        tx_start = 1'b1;
        push_frame(d);
        @(posedge clk);
        #1;
        tx_start = hold;
    endtask

    task automatic expect_bits(input int n, input string tag);
        exp_t e;
        int bt, bd, br;
        logic at, ad, ar;
        logic ed, er;
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL %s_queue: empty at bit %0d", tag, i);
                return;
            end
            e = exp_q.pop_front();
            bt = 0; bd = 0; br = 0;
            at = e.lvl; ad = 1'b0; ar = 1'b0;
            for (int c = 0; c < C; c++) begin
                @(negedge clk);
                ed = e.last && (c == C - 1);
                er = e.idle || ed;
                if (tx !== e.lvl) begin
                    if (bt == 0) at = tx;
                    bt++;
                end
                if (tx_done !== ed) begin
                    if (bd == 0) ad = tx_done;
                    bd++;
                end
                if (tx_ready !== er) begin
                    if (br == 0) ar = tx_ready;
                    br++;
                end
            end
            n_cmp += 2;
            if (bt != 0) begin
                n_bad++;
                $display("FAIL %s_tx bit%0d: tx=%b in %0d cycles, required %b",
                         tag, i, at, bt, e.lvl);
            end
            if (bd != 0) begin
                n_bad++;
                $display("FAIL %s_done bit%0d: tx_done=%b in %0d cycles, required pulse=%b",
                         tag, i, ad, bd, e.last);
            end
            if (br != 0) begin
                n_bad++;
                $display("FAIL %s_ready bit%0d: tx_ready=%b in %0d cycles, required idle=%b",
                         tag, i, ar, br, e.idle);
            end
        end
    endtask

    task automatic test_reset();
        int bt, bd, br;
        repeat (3) @(negedge clk);
        n_cmp += 3;
        if (tx !== 1'b1) begin
            n_bad++; $display("FAIL rst_tx: tx=%b required 1", tx);
        end
        if (tx_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst_ready: tx_ready=%b required 1", tx_ready);
        end
        if (tx_done !== 1'b0) begin
            n_bad++; $display("FAIL rst_done: tx_done=%b required 0", tx_done);
        end
        rst_n = 1'b1;
        bt = 0; bd = 0; br = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bt++;
            if (tx_done !== 1'b0) bd++;
            if (tx_ready !== 1'b1) br++;
        end
        n_cmp += 3;
        if (bt != 0) begin
            n_bad++; $display("FAIL idle_tx: %0d cycles not 1, required 0", bt);
        end
        if (bd != 0) begin
            n_bad++; $display("FAIL idle_done: %0d cycles high, required 0", bd);
        end
        if (br != 0) begin
            n_bad++; $display("FAIL idle_ready: %0d cycles low, required 0", br);
        end
    endtask

    task automatic test_basic();
        start_frame(8'hA5, 1'b0);
        push_idle(2);
        expect_bits(FB + 2, "basic_a5");
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        start_frame(8'hA5, 1'b0);
        push_idle(1);
        expect_bits(FB + 1, "par_a5");
        start_frame(8'h01, 1'b0);
        push_idle(1);
        expect_bits(FB + 1, "par_01");
    endtask
`endif

    task automatic test_ignore_busy();
        start_frame(8'h5A, 1'b0);
        push_idle(2);
        fork
            expect_bits(FB + 2, "ignore");
            begin
                repeat (4 * C + C / 2) @(posedge clk);
                #1;
                tx_data  = 8'hFF;
                tx_start = 1'b1;
                @(posedge clk);
                #1;
                tx_start = 1'b0;
            end
        join
    endtask

    task automatic test_back_to_back();
        start_frame(8'h55, 1'b1);
        tx_data = 8'hAA;
        push_frame(8'hAA);
        push_idle(1);
        fork
            expect_bits(2 * FB + 1, "b2b");
            begin
                repeat (F) @(posedge clk);
                #1;
                tx_start = 1'b0;
            end
        join
    endtask

    task automatic test_reset_mid();
        int bd;
        start_frame(8'h00, 1'b0);
        expect_bits(5, "rmid_pre");
        repeat (C / 2) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b0) begin
            n_bad++; $display("FAIL rmid_bit4: tx=%b required 0", tx);
        end
        rst_n = 1'b0;
        #1;
        n_cmp += 3;
        if (tx !== 1'b1) begin
            n_bad++; $display("FAIL rmid_tx: tx=%b required 1", tx);
        end
        if (tx_done !== 1'b0) begin
            n_bad++; $display("FAIL rmid_done: tx_done=%b required 0", tx_done);
        end
        if (tx_ready !== 1'b1) begin
            n_bad++; $display("FAIL rmid_ready: tx_ready=%b required 1", tx_ready);
        end
        exp_q.delete();
        bd = 0;
        repeat (4) begin
            @(negedge clk);
            if (tx_done !== 1'b0 || tx !== 1'b1) bd++;
        end
        n_cmp++;
        if (bd != 0) begin
            n_bad++; $display("FAIL rmid_hold: %0d bad cycles, required 0", bd);
        end
        rst_n = 1'b1;
        push_idle(2);
        expect_bits(2, "rmid_idle");
        start_frame(8'h3C, 1'b0);
        push_idle(1);
        expect_bits(FB + 1, "rmid_3c");
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
